gpio_port_ctrl: RTL

//  Core-side controller for a bank of WIDTH GPIO pad cells. Drives each cell's data-out (A) and direction (DIR).

---
 rtl/gpio_port_ctrl_pkg.sv | 21 ++
 rtl/gpio_port_ctrl_if.sv | 28 ++
 rtl/gpio_port_ctrl_in_filter.sv | 71 +++++++
 rtl/gpio_port_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/gpio_port_ctrl_pkg.sv
// Shared register map and pad-direction encodings for the GPIO bank controller.
// Debounce counter sizing helper is used only when GPIO_DEBOUNCE_EN is defined.
package gpio_pkg;

    localparam int GPIO_ADDR_W = 3;

    localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_DATA_OUT   = 3'd0;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_DIR        = 3'd1;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_DATA_IN    = 3'd2;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_RISE_EN    = 3'd3;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_FALL_EN    = 3'd4;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_IRQ_STATUS = 3'd5;

    localparam logic GPIO_DIR_IN  = 1'b1;
    localparam logic GPIO_DIR_OUT = 1'b0;

    function automatic int gpio_deb_cnt_w(input int deb_cycles);
        return (deb_cycles < 1) ? 1 : $clog2(deb_cycles + 1);
    endfunction

endpackage

// File: rtl/gpio_port_ctrl_if.sv
// Register request/response channel between the bus fabric (master) and the GPIO controller (slave).
// Both directions use valid/ready; a response is held until consumed.
interface gpio_port_ctrl_if
    import gpio_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [GPIO_ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]       req_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/gpio_port_ctrl_in_filter.sv
// One GPIO input bit: 2-flop synchronizer, optional debounce (GPIO_DEBOUNCE_EN), and edge detect.
// Edge outputs are combinational from the filtered value vs. its one-cycle-old copy; no backpressure.
module gpio_in_filter
    import gpio_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic y,
    input  logic dir,
    output logic out,
    output logic rise,
    output logic fall
);

    logic r_s1;
    logic r_s2;
    logic r_prev;
    logic w_filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= y;
            r_s2 <= r_s1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = gpio_deb_cnt_w(DEB_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic             r_filt;

    // Count consecutive cycles of disagreement; any return to agreement restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (r_s2 == r_filt) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
            r_cnt  <= '0;
            r_filt <= r_s2;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = r_s2;
`endif

    // prev always follows the filtered value, so a dir 0->1 switch sees prev == current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_filt;
        end
    end

    assign out  = w_filt;
    assign rise = (dir == GPIO_DIR_IN) &  w_filt & ~r_prev;
    assign fall = (dir == GPIO_DIR_IN) & ~w_filt &  r_prev;

endmodule

// File: rtl/gpio_port_ctrl.sv
// GPIO bank controller: register file, valid/ready register port, sticky edge IRQ (GPIO_DEBOUNCE_EN adds input debounce).
// Response one cycle after accept; req_ready = !rsp_valid || rsp_ready, so full throughput when responses drain.
module gpio_port_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    gpio_port_ctrl_if.slave    bus,
    output logic [WIDTH-1:0]   gpio_a,
    output logic [WIDTH-1:0]   gpio_dir,
    input  logic [WIDTH-1:0]   gpio_y,
    output logic               irq
);

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_irq_status;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_rdata;

    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_data_in;
    logic [WIDTH-1:0] w_irq_set;
    logic [WIDTH-1:0] w_irq_clr;
    logic [WIDTH-1:0] w_rdata;
    logic             w_accept;
    logic             w_wr;

    for (genvar i = 0; i < WIDTH; i++) begin : g_in
        gpio_in_filter #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_filt (
            .clk   (clk),
            .rst_n (rst_n),
            .y     (gpio_y[i]),
            .dir   (r_dir[i]),
            .out   (w_filt[i]),
            .rise  (w_rise[i]),
            .fall  (w_fall[i])
        );
    end

    assign bus.req_ready = !r_rsp_valid || bus.rsp_ready;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_wr          = w_accept && bus.req_write;

    // Output pins read back the driven value; Y is undefined while a cell drives.
    assign w_data_in = (r_dir & w_filt) | (~r_dir & r_data_out);

    always_comb begin
        w_rdata = '0;
        case (bus.req_addr)
            GPIO_ADDR_DATA_OUT:   w_rdata = r_data_out;
            GPIO_ADDR_DIR:        w_rdata = r_dir;
            GPIO_ADDR_DATA_IN:    w_rdata = w_data_in;
            GPIO_ADDR_RISE_EN:    w_rdata = r_rise_en;
            GPIO_ADDR_FALL_EN:    w_rdata = r_fall_en;
            GPIO_ADDR_IRQ_STATUS: w_rdata = r_irq_status;
            default:              w_rdata = '0;
        endcase
    end

    assign w_irq_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_irq_clr = (w_wr && (bus.req_addr == GPIO_ADDR_IRQ_STATUS)) ? bus.req_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
            r_dir      <= {WIDTH{GPIO_DIR_IN}};
            r_rise_en  <= '0;
            r_fall_en  <= '0;
        end else if (w_wr) begin
            case (bus.req_addr)
                GPIO_ADDR_DATA_OUT: r_data_out <= bus.req_wdata;
                GPIO_ADDR_DIR:      r_dir      <= bus.req_wdata;
                GPIO_ADDR_RISE_EN:  r_rise_en  <= bus.req_wdata;
                GPIO_ADDR_FALL_EN:  r_fall_en  <= bus.req_wdata;
                default: ;
            endcase
        end
    end

    // Set is applied after clear so a coincident new edge keeps the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_status <= '0;
        end else begin
            r_irq_status <= (r_irq_status & ~w_irq_clr) | w_irq_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= bus.req_write ? '0 : w_rdata;
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign gpio_a        = r_data_out;
    assign gpio_dir      = r_dir;
    assign irq           = |r_irq_status;

endmodule
